// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared response codes, FSM encoding and word geometry for the AXI-Lite memory slave
package axi_mem_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RMW_RD} state_t;
endpackage

// File: rtl/axi_strb_merge.sv
// axi_strb_merge: per-byte select between the stored word and the new write word
module axi_strb_merge
    import axi_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]         old_word,
    input  logic [DATA_W-1:0]         new_word,
    input  logic [BYTES_PER_WORD-1:0] strb,
    output logic [DATA_W-1:0]         merged
);
    for (genvar b = 0; b < BYTES_PER_WORD; b++) begin : g_byte
        assign merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite front end for a 128-byte word memory; define AXI_MEM_STRB_RMW_EN
// to honour WSTRB with a read-modify-write cycle for partial strobes.
module axi_lite_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ADDR_W-1:0]         AWADDR,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [DATA_W-1:0]         WDATA,
    input  logic [BYTES_PER_WORD-1:0] WSTRB,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [ADDR_W-1:0]         ARADDR,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [DATA_W-1:0]         RDATA,
    output logic [1:0]                RRESP,
    output logic                      MEM_CS,
    output logic                      MEM_WE,
    output logic [ADDR_W-1:0]         MEM_WADDR,
    output logic [ADDR_W-1:0]         MEM_RADDR,
    output logic [DATA_W-1:0]         MEM_WDATA,
    input  logic [DATA_W-1:0]         MEM_RDATA
);
    state_t state, state_d;
    logic prio_wr, prio_wr_d;
    logic grant_wr, grant_rd;
    logic bvalid_d, rvalid_d, cs_d, we_d;
    logic [1:0] bresp_d, rresp_d;
    logic [DATA_W-1:0] rdata_d, wdata_d;
    logic [ADDR_W-1:0] waddr_d, raddr_d;

    // prio_wr set means a simultaneous write request beats a read request
    assign grant_wr = (state == S_IDLE) && AWVALID && WVALID && (prio_wr || !ARVALID);
    assign grant_rd = (state == S_IDLE) && ARVALID && (!prio_wr || !(AWVALID && WVALID));
    assign AWREADY  = grant_wr;
    assign WREADY   = grant_wr;
    assign ARREADY  = grant_rd;

`ifdef AXI_MEM_STRB_RMW_EN
    logic [DATA_W-1:0] hold_wdata, merged;
    logic [BYTES_PER_WORD-1:0] hold_strb;

    // write beat is parked here while the old word is fetched
    always_ff @(posedge CLK) begin
        if (grant_wr) begin
            hold_wdata <= WDATA;
            hold_strb  <= WSTRB;
        end
    end

    axi_strb_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (MEM_RDATA),
        .new_word (hold_wdata),
        .strb     (hold_strb),
        .merged   (merged)
    );
`else
    logic unused_strb;
    assign unused_strb = ^WSTRB;
`endif

    always_comb begin
        state_d   = state;
        prio_wr_d = prio_wr;
        bvalid_d  = BVALID;
        bresp_d   = BRESP;
        rvalid_d  = RVALID;
        rresp_d   = RRESP;
        rdata_d   = RDATA;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        waddr_d   = MEM_WADDR;
        raddr_d   = MEM_RADDR;
        wdata_d   = MEM_WDATA;
        case (state)
            S_IDLE: begin
                if (grant_wr) begin
                    prio_wr_d = 1'b0;
                    if (|AWADDR[1:0]) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_SLVERR;
                    end
`ifdef AXI_MEM_STRB_RMW_EN
                    else if (WSTRB == '0) begin
                        state_d  = S_WRESP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else if (WSTRB != '1) begin
                        state_d = S_RMW_RD;
                        cs_d    = 1'b1;
                        raddr_d = AWADDR;
                        waddr_d = AWADDR;
                    end
`endif
                    else begin
                        state_d = S_WRITE;
                        cs_d    = 1'b1;
                        we_d    = 1'b1;
                        waddr_d = AWADDR;
                        wdata_d = WDATA;
                    end
                end else if (grant_rd) begin
                    prio_wr_d = 1'b1;
                    if (|ARADDR[1:0]) begin
                        state_d  = S_RDATA;
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_SLVERR;
                        rdata_d  = '0;
                    end else begin
                        state_d = S_READ;
                        cs_d    = 1'b1;
                        raddr_d = ARADDR;
                    end
                end
            end
            S_WRITE: begin
                state_d  = S_WRESP;
                bvalid_d = 1'b1;
                bresp_d  = RESP_OKAY;
            end
            S_WRESP: begin
                state_d  = BREADY ? S_IDLE : S_WRESP;
                bvalid_d = !BREADY;
            end
            S_READ: begin
                state_d  = S_RDATA;
                rvalid_d = 1'b1;
                rresp_d  = RESP_OKAY;
                rdata_d  = MEM_RDATA;
            end
            S_RDATA: begin
                state_d  = RREADY ? S_IDLE : S_RDATA;
                rvalid_d = !RREADY;
            end
`ifdef AXI_MEM_STRB_RMW_EN
            S_RMW_RD: begin
                state_d = S_WRITE;
                cs_d    = 1'b1;
                we_d    = 1'b1;
                wdata_d = merged;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            prio_wr   <= 1'b1;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            RVALID    <= 1'b0;
            RRESP     <= RESP_OKAY;
            RDATA     <= '0;
            MEM_CS    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_WADDR <= '0;
            MEM_RADDR <= '0;
            MEM_WDATA <= '0;
        end else begin
            state     <= state_d;
            prio_wr   <= prio_wr_d;
            BVALID    <= bvalid_d;
            BRESP     <= bresp_d;
            RVALID    <= rvalid_d;
            RRESP     <= rresp_d;
            RDATA     <= rdata_d;
            MEM_CS    <= cs_d;
            MEM_WE    <= we_d;
            MEM_WADDR <= waddr_d;
            MEM_RADDR <= raddr_d;
            MEM_WDATA <= wdata_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: scoreboard bench with a falling-edge word memory model
module tb_axi_lite_mem_slave;
    logic CLK = 1'b0, RST = 1'b1;
    logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic [6:0] AWADDR = '0, ARADDR = '0;
    logic [31:0] WDATA = '0, MEM_RDATA = '0;
    logic [3:0] WSTRB = '0;
    logic AWREADY, WREADY, BVALID, ARREADY, RVALID, MEM_CS, MEM_WE;
    logic [1:0] BRESP, RRESP;
    logic [31:0] RDATA, MEM_WDATA;
    logic [6:0] MEM_WADDR, MEM_RADDR;
    logic [31:0] mem [0:31];
    int n_checks = 0, n_fail = 0, we_cycles = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    axi_lite_mem_slave dut (
        .CLK(CLK), .RST(RST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR), .MEM_RADDR(MEM_RADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // memory writes and refreshes its read word on the falling edge
    always @(negedge CLK) begin
        if (MEM_WE) we_cycles++;
        if (MEM_CS && MEM_WE) mem[MEM_WADDR[6:2]] <= MEM_WDATA;
        if (MEM_CS && !MEM_WE) MEM_RDATA <= mem[MEM_RADDR[6:2]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // lat counts rising edges from the handshake cycle to the first cycle showing BVALID
    task automatic drive_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] r, output int lat);
        int t = 0;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        #1;
        while (!AWREADY && t < 20) begin @(posedge CLK); #1; t++; end
        @(posedge CLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; lat = 1;
        while (!BVALID && lat < 20) begin @(posedge CLK); #1; lat++; end
        r = BRESP;
        @(posedge CLK); #1;
    endtask

    task automatic drive_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r,
                              output int lat);
        int t = 0;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        #1;
        while (!ARREADY && t < 20) begin @(posedge CLK); #1; t++; end
        @(posedge CLK); #1;
        ARVALID = 1'b0; lat = 1;
        while (!RVALID && lat < 20) begin @(posedge CLK); #1; lat++; end
        d = RDATA; r = RRESP;
        @(posedge CLK); #1;
    endtask

    // write and read requested together; reports which side won the first grant
    task automatic do_both(input logic [6:0] wa, input logic [31:0] wd, input logic [6:0] ra,
                           output logic first_wr, output logic both_rdy, output logic [31:0] rd);
        int t = 0;
        rd = 'x;
        AWADDR = wa; WDATA = wd; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = ra; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        #1;
        while (!AWREADY && !ARREADY && t < 20) begin @(posedge CLK); #1; t++; end
        first_wr = AWREADY; both_rdy = AWREADY && ARREADY;
        @(posedge CLK); #1;
        if (first_wr) begin AWVALID = 1'b0; WVALID = 1'b0; end else ARVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (!BVALID && !RVALID && t < 20) begin @(posedge CLK); #1; t++; end
            if (RVALID) rd = RDATA;
            @(posedge CLK); #1;
            if (k == 0) begin
                t = 0;
                while (!AWREADY && !ARREADY && t < 20) begin @(posedge CLK); #1; t++; end
                @(posedge CLK); #1;
                AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        n_checks++; if ({BVALID, RVALID, MEM_CS, MEM_WE} !== 4'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got bv/rv/cs/we=%b want 0000", {BVALID, RVALID, MEM_CS, MEM_WE}); end
        n_checks++; if ({BRESP, RRESP} !== 4'b0) begin n_fail++;
            $display("FAIL reset_resp: got %b want 0000", {BRESP, RRESP}); end
        n_checks++; if (RDATA !== 32'h0 || MEM_WDATA !== 32'h0) begin n_fail++;
            $display("FAIL reset_data: got rdata=%h wdata=%h want 0", RDATA, MEM_WDATA); end
        n_checks++; if ({MEM_WADDR, MEM_RADDR} !== 14'h0) begin n_fail++;
            $display("FAIL reset_addr: got waddr=%h raddr=%h want 0", MEM_WADDR, MEM_RADDR); end
        n_checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b0) begin n_fail++;
            $display("FAIL reset_ready: got %b want 000", {AWREADY, WREADY, ARREADY}); end
    endtask

    task automatic test_write_read;
        exp_t e; logic [1:0] r; logic [31:0] d; int lat, we0;
        exp_q.push_back('{2'b00, 32'hDEADBEEF, 2});
        we0 = we_cycles;
        drive_write(7'h10, 32'hDEADBEEF, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++; if (r !== e.resp || lat !== e.lat) begin n_fail++;
            $display("FAIL wr_okay: got resp=%b lat=%0d want resp=%b lat=%0d", r, lat, e.resp, e.lat); end
        n_checks++; if (we_cycles - we0 !== 1) begin n_fail++;
            $display("FAIL wr_we_pulse: got %0d cycles want 1", we_cycles - we0); end
        n_checks++; if (MEM_WADDR !== 7'h10 || MEM_WDATA !== e.data || MEM_WE !== 1'b0) begin n_fail++;
            $display("FAIL wr_hold: got waddr=%h wdata=%h we=%b want 10/%h/0", MEM_WADDR, MEM_WDATA, MEM_WE, e.data); end
        exp_q.push_back('{2'b00, 32'hDEADBEEF, 2});
        drive_read(7'h10, d, r, lat);
        e = exp_q.pop_front();
        n_checks++; if (d !== e.data || r !== e.resp || lat !== e.lat) begin n_fail++;
            $display("FAIL rd_okay: got data=%h resp=%b lat=%0d want %h/%b/%0d", d, r, lat, e.data, e.resp, e.lat); end
    endtask

    task automatic test_misaligned;
        exp_t e; logic [1:0] r; logic [31:0] d; int lat, we0;
        exp_q.push_back('{2'b10, 32'h0, 1});
        we0 = we_cycles;
        drive_write(7'h13, 32'h12345678, 4'hF, r, lat);
        e = exp_q.pop_front();
        n_checks++; if (r !== e.resp || lat !== e.lat) begin n_fail++;
            $display("FAIL wr_slverr: got resp=%b lat=%0d want resp=%b lat=%0d", r, lat, e.resp, e.lat); end
        n_checks++; if (we_cycles - we0 !== 0) begin n_fail++;
            $display("FAIL wr_slverr_we: got %0d we cycles want 0", we_cycles - we0); end
        exp_q.push_back('{2'b10, 32'h0, 1});
        drive_read(7'h02, d, r, lat);
        e = exp_q.pop_front();
        n_checks++; if (d !== e.data || r !== e.resp || lat !== e.lat) begin n_fail++;
            $display("FAIL rd_slverr: got data=%h resp=%b lat=%0d want %h/%b/%0d", d, r, lat, e.data, e.resp, e.lat); end
    endtask

    task automatic test_priority;
        exp_t e; logic f, b; logic [1:0] r; logic [31:0] d; int lat;
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        exp_q.push_back('{2'b00, 32'hCAFEF00D, 1});
        do_both(7'h24, 32'hCAFEF00D, 7'h24, f, b, d);
        e = exp_q.pop_front();
        n_checks++; if (f !== 1'b1 || b !== 1'b0 || d !== e.data) begin n_fail++;
            $display("FAIL prio_first: got wr_first=%b both=%b data=%h want 1/0/%h", f, b, d, e.data); end
        exp_q.push_back('{2'b00, 32'hCAFEF00D, 1});
        do_both(7'h28, 32'h0BADF00D, 7'h24, f, b, d);
        e = exp_q.pop_front();
        n_checks++; if (f !== 1'b1 || b !== 1'b0 || d !== e.data) begin n_fail++;
            $display("FAIL prio_repeat: got wr_first=%b both=%b data=%h want 1/0/%h", f, b, d, e.data); end
        drive_write(7'h2C, 32'h12345678, 4'hF, r, lat);
        exp_q.push_back('{2'b00, 32'h12345678, 0});
        do_both(7'h2C, 32'h87654321, 7'h2C, f, b, d);
        e = exp_q.pop_front();
        n_checks++; if (f !== 1'b0 || b !== 1'b0 || d !== e.data) begin n_fail++;
            $display("FAIL prio_rr: got wr_first=%b both=%b data=%h want 0/0/%h", f, b, d, e.data); end
    endtask

    task automatic test_bready_stall;
        int t = 0;
        AWADDR = 7'h30; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        #1;
        while (!AWREADY && t < 20) begin @(posedge CLK); #1; t++; end
        @(posedge CLK); #1;
        AWADDR = 7'h34; ARADDR = 7'h30; ARVALID = 1'b1;
        t = 0;
        while (!BVALID && t < 20) begin @(posedge CLK); #1; t++; end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_fail++;
                $display("FAIL stall_b[%0d]: got bvalid=%b bresp=%b want 1/00", i, BVALID, BRESP); end
            n_checks++; if ({AWREADY, ARREADY} !== 2'b00) begin n_fail++;
                $display("FAIL stall_ready[%0d]: got aw/ar=%b want 00", i, {AWREADY, ARREADY}); end
            @(posedge CLK); #1;
        end
        BREADY = 1'b1;
        @(posedge CLK); #1;
        n_checks++; if (BVALID !== 1'b0 || ARREADY !== 1'b1 || AWREADY !== 1'b0) begin n_fail++;
            $display("FAIL stall_release: got bvalid=%b ar=%b aw=%b want 0/1/0", BVALID, ARREADY, AWREADY); end
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_strobe;
        exp_t e; logic [1:0] r; logic [31:0] d; int lat, we0;
        drive_write(7'h20, 32'h11223344, 4'hF, r, lat);
`ifdef AXI_MEM_STRB_RMW_EN
        exp_q.push_back('{2'b00, 32'h11BB33DD, 3});
`else
        exp_q.push_back('{2'b00, 32'hAABBCCDD, 2});
`endif
        drive_write(7'h20, 32'hAABBCCDD, 4'b0101, r, lat);
        e = exp_q.pop_front();
        n_checks++; if (r !== e.resp || lat !== e.lat) begin n_fail++;
            $display("FAIL strb_partial_b: got resp=%b lat=%0d want resp=%b lat=%0d", r, lat, e.resp, e.lat); end
        drive_read(7'h20, d, r, lat);
        n_checks++; if (d !== e.data) begin n_fail++;
            $display("FAIL strb_partial_data: got %h want %h", d, e.data); end
`ifdef AXI_MEM_STRB_RMW_EN
        exp_q.push_back('{2'b00, 32'h11BB33DD, 1});
`else
        exp_q.push_back('{2'b00, 32'h01020304, 2});
`endif
        we0 = we_cycles;
        drive_write(7'h20, 32'h01020304, 4'h0, r, lat);
        e = exp_q.pop_front();
        n_checks++; if (r !== e.resp || lat !== e.lat) begin n_fail++;
            $display("FAIL strb_zero_b: got resp=%b lat=%0d want resp=%b lat=%0d", r, lat, e.resp, e.lat); end
        n_checks++; if (we_cycles - we0 !== (e.lat == 1 ? 0 : 1)) begin n_fail++;
            $display("FAIL strb_zero_we: got %0d we cycles", we_cycles - we0); end
        drive_read(7'h20, d, r, lat);
        n_checks++; if (d !== e.data) begin n_fail++;
            $display("FAIL strb_zero_data: got %h want %h", d, e.data); end
    endtask

    task automatic test_reset_mid;
        int t = 0; logic [1:0] r; logic [31:0] d; int lat;
        ARADDR = 7'h10; ARVALID = 1'b1; RREADY = 1'b0;
        #1;
        while (!ARREADY && t < 20) begin @(posedge CLK); #1; t++; end
        @(posedge CLK); #1;
        ARVALID = 1'b0; t = 0;
        while (!RVALID && t < 20) begin @(posedge CLK); #1; t++; end
        @(posedge CLK); #1;
        n_checks++; if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL rd_hold: got rvalid=%b rdata=%h want 1/deadbeef", RVALID, RDATA); end
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        n_checks++; if (RVALID !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset_rvalid: got %b want 0", RVALID); end
        ARVALID = 1'b1;
        #1;
        n_checks++; if (ARREADY !== 1'b1) begin n_fail++;
            $display("FAIL mid_reset_arready: got %b want 1", ARREADY); end
        drive_read(7'h10, d, r, lat);
        n_checks++; if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 2) begin n_fail++;
            $display("FAIL mid_reset_read: got data=%h resp=%b lat=%0d want deadbeef/00/2", d, r, lat); end
    endtask

    task automatic test_back_to_back;
        exp_t e; logic [1:0] r; logic [31:0] d; int lat;
        logic [31:0] wd [4];
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            exp_q.push_back('{2'b00, wd[i], 2});
            drive_write(7'(8'h40 + 4 * i), wd[i], 4'hF, r, lat);
            e = exp_q.pop_front();
            n_checks++; if (r !== e.resp || lat !== e.lat) begin n_fail++;
                $display("FAIL b2b_wr[%0d]: got resp=%b lat=%0d want %b/%0d", i, r, lat, e.resp, e.lat); end
        end
        for (int i = 0; i < 4; i++) exp_q.push_back('{2'b00, wd[i], 2});
        for (int i = 0; i < 4; i++) begin
            drive_read(7'(8'h40 + 4 * i), d, r, lat);
            e = exp_q.pop_front();
            n_checks++; if (d !== e.data || r !== e.resp || lat !== e.lat) begin n_fail++;
                $display("FAIL b2b_rd[%0d]: got %h/%b/%0d want %h/%b/%0d", i, d, r, lat, e.data, e.resp, e.lat); end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_misaligned;
        test_priority;
        test_bready_stall;
        test_strobe;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
AXI4-Lite slave front end that sits directly upstream of the 128-byte byte-addressed word memory. It converts AW/W/B and AR/R channel handshakes into memory strobes: CS, WE, write address, read address and write data. It captures the memory's registered read word and returns it on R. Each 32-bit word occupies 4 consecutive bytes, little-endian. The memory writes and updates its read output on the falling CLK edge.

Parameters:
ADDR_W, 7, byte address width (128-byte space)
DATA_W, 32, data width; fixed at 4 bytes per beat

Ports:
CLK  in  1  rising-edge clock, shared with memory
RST  in  1  synchronous, active-high reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  ADDR_W  write byte address
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_W  write data
WSTRB  in  4  byte strobes (used only with feature)
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  ADDR_W  read byte address
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
MEM_CS  out  1  memory chip select
MEM_WE  out  1  memory write enable
MEM_WADDR  out  ADDR_W  memory write byte address
MEM_RADDR  out  ADDR_W  memory read byte address
MEM_WDATA  out  DATA_W  memory write word
MEM_RDATA  in  DATA_W  memory read word (valid after falling edge)

Behaviour:
- Reset (sync, at rising edge with RST=1):
  - state=IDLE; BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0.
  - MEM_CS=MEM_WE=0; MEM_WADDR=MEM_RADDR=0; MEM_WDATA=0.
  - Priority flag = write-first.
- Ready decoding: AWREADY/WREADY/ARREADY are combinational from state and valids. All other outputs are registered.
- IDLE:
  - A write is requestable only when AWVALID&&WVALID. AWREADY and WREADY assert together; the AW and W handshakes always complete in the same cycle.
  - A read is requestable when ARVALID.
  - If both are requestable, the priority flag picks the winner. The flag toggles to the other side after each grant (round-robin).
  - Only one transaction is outstanding at a time.
- Address check: ADDR[1:0]!=0 → SLVERR (2'b10) with no memory access. For reads, RDATA=0. An aligned address is always in range (0..124).
- Write, aligned: accept at edge N.
  - WRITE state for cycle N+1: MEM_CS=MEM_WE=1, MEM_WADDR/MEM_WDATA latched. The memory writes on that falling edge.
  - BVALID=1, BRESP=OKAY from edge N+2 (WRESP state), held until BREADY is sampled high. Then IDLE; MEM_CS/WE return to 0.
- Read, aligned: accept at edge N.
  - READ state for cycle N+1: MEM_CS=1, MEM_WE=0, MEM_RADDR latched.
  - Edge N+2: RDATA<=MEM_RDATA, RVALID=1, RRESP=OKAY (RDATA state), held stable until RREADY. Then IDLE.
- Error transactions go straight from IDLE to WRESP/RDATA at edge N+1.
- MEM_RADDR/MEM_WADDR/MEM_WDATA hold their last values when idle. MEM_WE=1 never occurs outside WRITE.
- RST asserted mid-transaction abandons it; no B or R is issued. A write already in its WRITE cycle completes in memory.
- A read of a word written by the immediately preceding transaction returns the new data.

Optional Feature:
- Macro: AXI_MEM_STRB_RMW_EN.
- Without it: WSTRB is ignored and all 4 bytes are written.
- With it:
  - WSTRB==4'hF: direct write, as above.
  - WSTRB==4'h0: no memory access; BRESP=OKAY at N+1.
  - Partial strobe: RMW_RD state (MEM_CS=1, MEM_RADDR=addr). At the next edge, merge MEM_RDATA with WDATA per strobe, then WRITE. Adds 1 cycle; BVALID at N+3.

Decomposition:
- Package axi_mem_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - State encoding: IDLE, WRITE, WRESP, READ, RDATA, RMW_RD.
  - BYTES_PER_WORD=4.
- One natural sub-module: axi_strb_merge, a combinational byte merge of old word, new word and strobe. Instantiated only under AXI_MEM_STRB_RMW_EN.

Test Plan:
- Write AWADDR=0x10, WDATA=0xDEADBEEF with BREADY=1 → MEM_WE high exactly one cycle, BVALID at N+2 with BRESP=0. Then read ARADDR=0x10 → RVALID at N+2 with RDATA=0xDEADBEEF.
- AWADDR=0x13 → BRESP=2'b10, MEM_WE never asserted. ARADDR=0x02 → RRESP=2'b10, RDATA=0.
- AW/W and AR valid together from reset → write granted first, read next. Repeat → write then read again (alternation).
- BREADY held low 3 cycles after BVALID → BVALID/BRESP stable, no new AWREADY/ARREADY until BREADY=1.
- Feature on: word 0x20=0x11223344, write WDATA=0xAABBCCDD with WSTRB=4'b0101 → read returns 0x11BB33DD, BVALID at N+3.
- RST pulsed during RDATA state with RREADY=0 → next cycle RVALID=0, state IDLE, ARREADY asserts for a new ARVALID.
